// File: rtl/approx_mul_err_pkg.sv
// rtl/approx_mul_err_pkg.sv - shared types, default widths and saturating add for the error monitor
package approx_mul_err_pkg;

    localparam int DEF_IN_W    = 6;
    localparam int DEF_OUT_W   = 12;
    localparam int DEF_SAMPLES = 4096;
    localparam int DEF_CNT_W   = 13;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_SQ_W    = 36;
    localparam int SAT_MAX_W   = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Callers zero-extend into 64 bits; the result is clamped to the w-bit all-ones value.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/err_sat_acc.sv
// rtl/err_sat_acc.sv - width-parameterised saturating accumulator with sync clear and enable
module err_sat_acc
    import approx_mul_err_pkg::*;
#(
    parameter int W    = DEF_ACC_W,
    parameter int IN_W = DEF_OUT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] inc,
    output logic [W-1:0]    acc
);

    if (W > SAT_MAX_W || IN_W > SAT_MAX_W) begin : g_bad_w
        $fatal(1, "err_sat_acc: width exceeds supported maximum");
    end

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = W'(sat_add(64'(acc_q), 64'(inc), W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/approx_mul_err_monitor.sv
// rtl/approx_mul_err_monitor.sv - recomputes exact products and accumulates approximate-multiplier error metrics
module approx_mul_err_monitor
    import approx_mul_err_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SQ_W    = DEF_SQ_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  op_a,
    input  logic [IN_W-1:0]  op_b,
    input  logic [OUT_W-1:0] approx_p,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [SQ_W-1:0]  err_sq_sum,
    output logic [OUT_W-1:0] err_max
);

    if (OUT_W != 2 * IN_W) begin : g_bad_out_w
        $fatal(1, "approx_mul_err_monitor: OUT_W must equal 2*IN_W");
    end
    if (SAMPLES < 1 || SAMPLES > (2 ** CNT_W) - 1) begin : g_bad_samples
        $fatal(1, "approx_mul_err_monitor: SAMPLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [OUT_W-1:0]   err_max_q, err_max_d;
    logic               s1_v_q, s1_v_d;
    logic [OUT_W-1:0]   exact_q, exact_d;
    logic [OUT_W-1:0]   approx_q, approx_d;

    logic               start_ok;
    logic               accept;
    logic               last_accept;
    logic [OUT_W-1:0]   diff;
    logic [2*OUT_W-1:0] diff_sq;

    assign start_ok    = start && (state_q == IDLE || state_q == DONE);
    assign accept      = in_valid && (state_q == RUN);
    assign last_accept = accept && (sample_cnt_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_accept) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // The last sample is folded into the metrics on this same edge.
                if (!s1_v_d) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: capture the exact product alongside the multiplier's answer.
    always_comb begin
        s1_v_d   = accept;
        exact_d  = exact_q;
        approx_d = approx_q;
        if (accept) begin
            exact_d  = OUT_W'(op_a) * OUT_W'(op_b);
            approx_d = approx_p;
        end
    end

    // Stage 2: absolute error and the metric updates that consume it.
    always_comb begin
        diff    = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
        diff_sq = (2 * OUT_W)'(diff) * (2 * OUT_W)'(diff);
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_max_d    = err_max_q;
        if (start_ok) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            err_max_d    = '0;
        end else begin
            if (accept) sample_cnt_d = sample_cnt_q + 1'b1;
            if (s1_v_q && diff != '0) err_cnt_d = err_cnt_q + 1'b1;
            if (s1_v_q && diff > err_max_q) err_max_d = diff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_max_q    <= '0;
            s1_v_q       <= 1'b0;
            exact_q      <= '0;
            approx_q     <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_max_q    <= err_max_d;
            s1_v_q       <= s1_v_d;
            exact_q      <= exact_d;
            approx_q     <= approx_d;
        end
    end

    err_sat_acc #(
        .W    (ACC_W),
        .IN_W (OUT_W)
    ) u_sum_acc (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (s1_v_q),
        .inc (diff),
        .acc (err_sum)
    );

    err_sat_acc #(
        .W    (SQ_W),
        .IN_W (2 * OUT_W)
    ) u_sq_acc (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (s1_v_q),
        .inc (diff_sq),
        .acc (err_sq_sum)
    );

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_max    = err_max_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb/tb_approx_mul_err_monitor.sv - directed self-checking bench for approx_mul_err_monitor
module tb_approx_mul_err_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start    [4];
    logic        in_valid [4];
    logic        in_ready [4];
    logic        busy     [4];
    logic        done     [4];
    logic [12:0] sample_cnt [4];
    logic [12:0] err_cnt    [4];
    logic [23:0] err_sum    [3];
    logic [7:0]  err_sum_sat;
    logic [35:0] err_sq_sum [4];
    logic [11:0] err_max    [4];
    logic [5:0]  op_a = '0;
    logic [5:0]  op_b = '0;
    logic [11:0] approx_p = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_mul_err_monitor u_full (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_a(op_a), .op_b(op_b), .approx_p(approx_p), .busy(busy[0]), .done(done[0]),
        .sample_cnt(sample_cnt[0]), .err_cnt(err_cnt[0]), .err_sum(err_sum[0]),
        .err_sq_sum(err_sq_sum[0]), .err_max(err_max[0])
    );

    approx_mul_err_monitor #(.SAMPLES(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_a(op_a), .op_b(op_b), .approx_p(approx_p), .busy(busy[1]), .done(done[1]),
        .sample_cnt(sample_cnt[1]), .err_cnt(err_cnt[1]), .err_sum(err_sum[1]),
        .err_sq_sum(err_sq_sum[1]), .err_max(err_max[1])
    );

    approx_mul_err_monitor #(.SAMPLES(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op_a(op_a), .op_b(op_b), .approx_p(approx_p), .busy(busy[2]), .done(done[2]),
        .sample_cnt(sample_cnt[2]), .err_cnt(err_cnt[2]), .err_sum(err_sum[2]),
        .err_sq_sum(err_sq_sum[2]), .err_max(err_max[2])
    );

    approx_mul_err_monitor #(.ACC_W(8), .SAMPLES(4)) u_sat (
        .clk(clk), .rst(rst), .start(start[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .op_a(op_a), .op_b(op_b), .approx_p(approx_p), .busy(busy[3]), .done(done[3]),
        .sample_cnt(sample_cnt[3]), .err_cnt(err_cnt[3]), .err_sum(err_sum_sat),
        .err_sq_sum(err_sq_sum[3]), .err_max(err_max[3])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    task automatic send(input int i, input int a, input int b, input int p);
        op_a        = 6'(a);
        op_b        = 6'(b);
        approx_p    = 12'(p);
        in_valid[i] = 1'b1;
        tick(1);
        in_valid[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start[i]    = 1'b0;
            in_valid[i] = 1'b0;
        end
        #23 rst = 1'b0;
        tick(1);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_ready%0d", i), 64'(in_ready[i]), 64'd0);
            check($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
            check($sformatf("rst_done%0d", i), 64'(done[i]), 64'd0);
            check($sformatf("rst_scnt%0d", i), 64'(sample_cnt[i]), 64'd0);
        end
        check("rst_err_sum", 64'(err_sum[0]), 64'd0);
        check("rst_err_max", 64'(err_max[0]), 64'd0);

        // Exhaustive run with a perfect multiplier.
        pulse_start(0);
        check("t1_ready", 64'(in_ready[0]), 64'd1);
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                op_a        = 6'(a);
                op_b        = 6'(b);
                approx_p    = 12'(a * b);
                in_valid[0] = 1'b1;
                tick(1);
            end
        end
        in_valid[0] = 1'b0;
        check("t1_ready_drop", 64'(in_ready[0]), 64'd0);
        check("t1_busy_drain", 64'(busy[0]), 64'd1);
        check("t1_done_early", 64'(done[0]), 64'd0);
        tick(1);
        check("t1_done", 64'(done[0]), 64'd1);
        check("t1_busy", 64'(busy[0]), 64'd0);
        check("t1_scnt", 64'(sample_cnt[0]), 64'd4096);
        check("t1_ecnt", 64'(err_cnt[0]), 64'd0);
        check("t1_sum", 64'(err_sum[0]), 64'd0);
        check("t1_sq", 64'(err_sq_sum[0]), 64'd0);
        check("t1_max", 64'(err_max[0]), 64'd0);

        // Single sample; start and in_valid together in IDLE must not accept.
        op_a        = 6'd63;
        op_b        = 6'd63;
        approx_p    = 12'd3937;
        start[1]    = 1'b1;
        in_valid[1] = 1'b1;
        tick(1);
        start[1] = 1'b0;
        check("t2_no_early_accept", 64'(sample_cnt[1]), 64'd0);
        tick(1);
        in_valid[1] = 1'b0;
        check("t2_scnt", 64'(sample_cnt[1]), 64'd1);
        check("t2_ready_drop", 64'(in_ready[1]), 64'd0);
        check("t2_done_early", 64'(done[1]), 64'd0);
        tick(1);
        check("t2_done", 64'(done[1]), 64'd1);
        check("t2_ecnt", 64'(err_cnt[1]), 64'd1);
        check("t2_sum", 64'(err_sum[1]), 64'd32);
        check("t2_sq", 64'(err_sq_sum[1]), 64'd1024);
        check("t2_max", 64'(err_max[1]), 64'd32);

        // Three samples, errors +5, -7, 0, with gaps.
        pulse_start(2);
        send(2, 10, 10, 95);
        send(2, 3, 4, 19);
        tick(3);
        send(2, 7, 9, 63);
        check("t3_done_early", 64'(done[2]), 64'd0);
        tick(1);
        check("t3_done", 64'(done[2]), 64'd1);
        check("t3_scnt", 64'(sample_cnt[2]), 64'd3);
        check("t3_ecnt", 64'(err_cnt[2]), 64'd2);
        check("t3_sum", 64'(err_sum[2]), 64'd12);
        check("t3_sq", 64'(err_sq_sum[2]), 64'd74);
        check("t3_max", 64'(err_max[2]), 64'd7);

        // start in DONE clears; start in RUN and DRAIN ignored.
        pulse_start(2);
        check("t6_busy", 64'(busy[2]), 64'd1);
        check("t6_ready", 64'(in_ready[2]), 64'd1);
        check("t6_clr_scnt", 64'(sample_cnt[2]), 64'd0);
        check("t6_clr_ecnt", 64'(err_cnt[2]), 64'd0);
        check("t6_clr_sum", 64'(err_sum[2]), 64'd0);
        check("t6_clr_sq", 64'(err_sq_sum[2]), 64'd0);
        check("t6_clr_max", 64'(err_max[2]), 64'd0);
        send(2, 1, 1, 0);
        pulse_start(2);
        check("t6_run_scnt", 64'(sample_cnt[2]), 64'd1);
        check("t6_run_ecnt", 64'(err_cnt[2]), 64'd1);
        send(2, 2, 2, 5);
        send(2, 2, 3, 5);
        pulse_start(2);
        check("t6_done", 64'(done[2]), 64'd1);
        check("t6_busy_end", 64'(busy[2]), 64'd0);
        check("t6_scnt", 64'(sample_cnt[2]), 64'd3);
        check("t6_ecnt", 64'(err_cnt[2]), 64'd3);
        check("t6_sum", 64'(err_sum[2]), 64'd3);
        check("t6_sq", 64'(err_sq_sum[2]), 64'd3);

        // Narrow absolute-error accumulator saturates.
        pulse_start(3);
        for (int k = 0; k < 4; k++) send(3, 63, 63, 3869);
        tick(1);
        check("t4_done", 64'(done[3]), 64'd1);
        check("t4_ecnt", 64'(err_cnt[3]), 64'd4);
        check("t4_sum_sat", 64'(err_sum_sat), 64'd255);
        check("t4_sq", 64'(err_sq_sum[3]), 64'd40000);
        check("t4_max", 64'(err_max[3]), 64'd100);

        // Reset in the middle of a run.
        pulse_start(0);
        for (int k = 0; k < 10; k++) send(0, 1, 1, 0);
        tick(1);
        check("t5_pre_ecnt", 64'(err_cnt[0]), 64'd10);
        rst = 1'b1;
        #2;
        check("t5_rst_scnt", 64'(sample_cnt[0]), 64'd0);
        check("t5_rst_ecnt", 64'(err_cnt[0]), 64'd0);
        check("t5_rst_sum", 64'(err_sum[0]), 64'd0);
        check("t5_rst_max", 64'(err_max[0]), 64'd0);
        check("t5_rst_busy", 64'(busy[0]), 64'd0);
        check("t5_rst_ready", 64'(in_ready[0]), 64'd0);
        #1 rst = 1'b0;
        tick(1);
        check("t5_idle", 64'(busy[0]), 64'd0);
        pulse_start(0);
        check("t5_ready", 64'(in_ready[0]), 64'd1);
        check("t5_scnt0", 64'(sample_cnt[0]), 64'd0);
        send(0, 5, 5, 25);
        check("t5_scnt1", 64'(sample_cnt[0]), 64'd1);
        tick(1);
        check("t5_ecnt", 64'(err_cnt[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
